// File: rtl/vsbc_pkg.sv
// ---------------------------------------------------------------------------
// vsbc_pkg: shared types and helpers for the variable-shift binary counter.
//   vsbc_state_e : run-control FSM states (IDLE / RUN / DONE)
//   align_weight : places the narrow initial weight at the top of the
//                  wider weight register
// ---------------------------------------------------------------------------
package vsbc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vsbc_state_e;

  // Left-justifies a W-bit weight inside a B_W-bit register by padding
  // `pad` zeros below it. Operates at 64 bits; callers cast to their width.
  function automatic logic [63:0] align_weight(input logic [63:0] k,
                                               input int unsigned pad);
    return k << pad;
  endfunction

endpackage

// File: rtl/vsbc_lane.sv
// ---------------------------------------------------------------------------
// vsbc_lane: one accumulator lane of the counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear accumulator and saturation flag (run start)
//   en       : accept a beat this cycle
//   z        : stochastic bit; add the weight when 1
//   rshift   : halve the lane result after the add
//   k        : current shared weight
//   acc      : accumulator value
//   sat      : sticky saturation flag, set when an add carries out
// ---------------------------------------------------------------------------
module vsbc_lane #(
  parameter int B_W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic           z,
  input  logic           rshift,
  input  logic [B_W-1:0] k,
  output logic [B_W-1:0] acc,
  output logic           sat
);

  logic [B_W:0]   sum;
  logic [B_W-1:0] clamped;
  logic [B_W-1:0] result;

  // NOTE: every signal gets a value on every path of an always_comb,
  // otherwise synthesis infers a latch to hold the missing case.
  always_comb begin
    sum     = {1'b0, acc} + (z ? {1'b0, k} : '0);
    clamped = sum[B_W] ? '1 : sum[B_W-1:0];
    // Shift happens after the clamp, so a saturated lane halves to 0x7F..F.
    result  = rshift ? (clamped >> 1) : clamped;
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (en) begin
      acc <= result;
      if (sum[B_W]) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/vsbc_mc.sv
// ---------------------------------------------------------------------------
// vsbc_mc: multi-channel variable-shift binary counter with run control.
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin a run (accepted in IDLE or DONE)
//   k_init    : initial weight, left-justified into k_cur on start
//   len       : maximum beats for the run
//   z_valid   : beat qualifier for z and rshift
//   z         : one stochastic bit per lane
//   rshift    : halve weight and accumulators this beat
//   stop      : early-termination request (any RUN cycle)
//   busy/done : high in RUN / DONE
//   bz        : accumulators, lane i at [i*B_W +: B_W]
//   sat       : sticky per-lane saturation flags
//   k_cur     : current weight
//   beats     : beats accepted in the current or last run
// ---------------------------------------------------------------------------
module vsbc_mc
  import vsbc_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int W     = 4,
  parameter int B_W   = 12,
  parameter int CNT_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [W-1:0]        k_init,
  input  logic [CNT_W-1:0]    len,
  input  logic                z_valid,
  input  logic [N_CH-1:0]     z,
  input  logic                rshift,
  input  logic                stop,
  output logic                busy,
  output logic                done,
  output logic [N_CH*B_W-1:0] bz,
  output logic [N_CH-1:0]     sat,
  output logic [B_W-1:0]      k_cur,
  output logic [CNT_W-1:0]    beats
);

  vsbc_state_e      state_q, state_d;
  logic [CNT_W-1:0] len_q;
  logic [B_W-1:0]   k_load, k_next;
  logic [CNT_W-1:0] beats_next;
  logic             start_ok, beat;

  assign start_ok   = start && (state_q != RUN);
  assign beat       = (state_q == RUN) && z_valid;
  assign k_load     = B_W'(align_weight(64'(k_init), B_W - W));
  assign k_next     = rshift ? (k_cur >> 1) : k_cur;
  assign beats_next = beats + 1'b1;

  // Termination tests look at post-beat values so the final beat is applied.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) state_d = (k_init == '0 || len == '0) ? DONE : RUN;
      end
      RUN: begin
        if (stop || (beat && (beats_next == len_q || k_next == '0)))
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset clears only control/weight state here; lane accumulators
  // carry their own reset, so every visible output returns to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_cur   <= '0;
      beats   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        k_cur <= k_load;
        beats <= '0;
        len_q <= len;
      end else if (beat) begin
        k_cur <= k_next;
        beats <= beats_next;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    vsbc_lane #(.B_W(B_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (start_ok),
      .en     (beat),
      .z      (z[i]),
      .rshift (rshift),
      .k      (k_cur),
      .acc    (bz[i*B_W +: B_W]),
      .sat    (sat[i])
    );
  end

endmodule

// File: tb/tb_vsbc_mc.sv
module tb_vsbc_mc;

  localparam int N_CH  = 2;
  localparam int W     = 4;
  localparam int B_W   = 8;
  localparam int CNT_W = 10;

  logic                clk = 1'b0;
  logic                rst, start, z_valid, rshift, stop;
  logic [W-1:0]        k_init;
  logic [CNT_W-1:0]    len;
  logic [N_CH-1:0]     z;
  logic                busy, done;
  logic [N_CH*B_W-1:0] bz;
  logic [N_CH-1:0]     sat;
  logic [B_W-1:0]      k_cur;
  logic [CNT_W-1:0]    beats;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vsbc_mc #(.N_CH(N_CH), .W(W), .B_W(B_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .k_init(k_init), .len(len),
    .z_valid(z_valid), .z(z), .rshift(rshift), .stop(stop),
    .busy(busy), .done(done), .bz(bz), .sat(sat), .k_cur(k_cur), .beats(beats)
  );

  // Observed tuple: {busy, done, lane0, lane1, sat, k_cur, beats}
  typedef logic [37:0] obs_t;

  typedef struct {
    logic       r, s;
    logic [3:0] k;
    logic [9:0] l;
    logic       zv;
    logic [1:0] zz;
    logic       rs, stp;
    logic       e_busy, e_done;
    logic [7:0] e_b0, e_b1;
    logic [1:0] e_sat;
    logic [7:0] e_k;
    logic [9:0] e_beats;
  } row_t;

  row_t rows[$];

  function automatic row_t mk(input logic r, s, input logic [3:0] k,
      input logic [9:0] l, input logic zv, input logic [1:0] zz,
      input logic rs, stp, e_busy, e_done, input logic [7:0] e_b0, e_b1,
      input logic [1:0] e_sat, input logic [7:0] e_k, input logic [9:0] e_beats);
    row_t t;
    t.r = r; t.s = s; t.k = k; t.l = l; t.zv = zv; t.zz = zz; t.rs = rs;
    t.stp = stp; t.e_busy = e_busy; t.e_done = e_done; t.e_b0 = e_b0;
    t.e_b1 = e_b1; t.e_sat = e_sat; t.e_k = e_k; t.e_beats = e_beats;
    return t;
  endfunction

  function automatic obs_t observed();
    return {busy, done, bz[7:0], bz[15:8], sat, k_cur, beats};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, s, input logic [3:0] k, input logic [9:0] l,
                       input logic zv, input logic [1:0] zz, input logic rs, stp);
    rst = r; start = s; k_init = k; len = l; z_valid = zv; z = zz;
    rshift = rs; stop = stp;
    @(posedge clk);
    #1;
  endtask

  // Reference model state, kept as plain integers.
  int m_mode;            // 0 idle, 1 run, 2 done
  int m_acc[N_CH];
  int m_sat, m_k, m_beats, m_len;

  task automatic model_step(input logic r, s, input logic [3:0] k,
      input logic [9:0] l, input logic zv, input logic [1:0] zz, input logic rs, stp);
    if (r) begin
      m_mode = 0; m_sat = 0; m_k = 0; m_beats = 0; m_len = 0;
      foreach (m_acc[i]) m_acc[i] = 0;
    end else if (s && m_mode != 1) begin
      foreach (m_acc[i]) m_acc[i] = 0;
      m_sat = 0; m_beats = 0; m_len = int'(l);
      m_k = int'(k) * (2 ** (B_W - W));
      m_mode = (k == 0 || l == 0) ? 2 : 1;
    end else if (m_mode == 1) begin
      if (zv) begin
        foreach (m_acc[i]) begin
          int sum;
          sum = m_acc[i] + (zz[i] ? m_k : 0);
          if (sum > 255) begin
            sum = 255;
            m_sat = m_sat | (1 << i);
          end
          if (rs) sum = sum / 2;
          m_acc[i] = sum;
        end
        if (rs) m_k = m_k / 2;
        m_beats++;
      end
      if (stp || (zv && (m_beats == m_len || m_k == 0))) m_mode = 2;
    end
  endtask

  function automatic obs_t model_obs();
    return {m_mode == 1, m_mode == 2, 8'(m_acc[0]), 8'(m_acc[1]),
            2'(m_sat), 8'(m_k), 10'(m_beats)};
  endfunction

  initial begin
    //                 r  s  k  len zv z     rs stp   busy done b0   b1  sat   k    beats
    rows.push_back(mk(1, 0, 0, 0,  0, 2'b00, 0, 0,    0, 0,   0,   0,  2'b00, 0,   0));
    // Basic accumulate, length limit
    rows.push_back(mk(0, 1, 2, 3,  0, 2'b00, 0, 0,    1, 0,   0,   0,  2'b00, 32,  0));
    rows.push_back(mk(0, 0, 0, 0,  1, 2'b01, 0, 0,    1, 0,   32,  0,  2'b00, 32,  1));
    rows.push_back(mk(0, 0, 0, 0,  1, 2'b01, 0, 0,    1, 0,   64,  0,  2'b00, 32,  2));
    rows.push_back(mk(0, 0, 0, 0,  1, 2'b01, 0, 0,    0, 1,   96,  0,  2'b00, 32,  3));
    rows.push_back(mk(0, 0, 0, 0,  0, 2'b00, 0, 0,    0, 1,   96,  0,  2'b00, 32,  3));
    // Shift, start ignored in RUN, stop without beat, DONE holds
    rows.push_back(mk(0, 1, 2, 5,  0, 2'b00, 0, 0,    1, 0,   0,   0,  2'b00, 32,  0));
    rows.push_back(mk(0, 0, 0, 0,  1, 2'b11, 1, 0,    1, 0,   16,  16, 2'b00, 16,  1));
    rows.push_back(mk(0, 0, 0, 0,  1, 2'b01, 0, 0,    1, 0,   32,  16, 2'b00, 16,  2));
    rows.push_back(mk(0, 1, 8, 1,  0, 2'b00, 0, 0,    1, 0,   32,  16, 2'b00, 16,  2));
    rows.push_back(mk(0, 0, 0, 0,  0, 2'b00, 0, 1,    0, 1,   32,  16, 2'b00, 16,  2));
    rows.push_back(mk(0, 0, 0, 0,  1, 2'b11, 1, 0,    0, 1,   32,  16, 2'b00, 16,  2));
    // Saturation
    rows.push_back(mk(0, 1, 8, 3,  0, 2'b00, 0, 0,    1, 0,   0,   0,  2'b00, 128, 0));
    rows.push_back(mk(0, 0, 0, 0,  1, 2'b01, 0, 0,    1, 0,   128, 0,  2'b00, 128, 1));
    rows.push_back(mk(0, 0, 0, 0,  1, 2'b01, 0, 0,    1, 0,   255, 0,  2'b01, 128, 2));
    rows.push_back(mk(0, 0, 0, 0,  1, 2'b01, 0, 0,    0, 1,   255, 0,  2'b01, 128, 3));
    // Weight exhaustion
    rows.push_back(mk(0, 1, 1, 15, 0, 2'b00, 0, 0,    1, 0,   0,   0,  2'b00, 16,  0));
    rows.push_back(mk(0, 0, 0, 0,  1, 2'b01, 1, 0,    1, 0,   8,   0,  2'b00, 8,   1));
    rows.push_back(mk(0, 0, 0, 0,  1, 2'b01, 1, 0,    1, 0,   8,   0,  2'b00, 4,   2));
    rows.push_back(mk(0, 0, 0, 0,  1, 2'b01, 1, 0,    1, 0,   6,   0,  2'b00, 2,   3));
    rows.push_back(mk(0, 0, 0, 0,  1, 2'b01, 1, 0,    1, 0,   4,   0,  2'b00, 1,   4));
    rows.push_back(mk(0, 0, 0, 0,  1, 2'b01, 1, 0,    0, 1,   2,   0,  2'b00, 0,   5));
    // Zero-length and zero-weight starts go straight to DONE
    rows.push_back(mk(0, 1, 3, 0,  0, 2'b00, 0, 0,    0, 1,   0,   0,  2'b00, 48,  0));
    rows.push_back(mk(0, 1, 0, 4,  0, 2'b00, 0, 0,    0, 1,   0,   0,  2'b00, 0,   0));
    // Reset mid-run, then a normal run ending on stop + length together
    rows.push_back(mk(0, 1, 2, 9,  0, 2'b00, 0, 0,    1, 0,   0,   0,  2'b00, 32,  0));
    rows.push_back(mk(0, 0, 0, 0,  1, 2'b11, 0, 0,    1, 0,   32,  32, 2'b00, 32,  1));
    rows.push_back(mk(0, 0, 0, 0,  1, 2'b10, 0, 0,    1, 0,   32,  64, 2'b00, 32,  2));
    rows.push_back(mk(1, 0, 0, 0,  1, 2'b11, 0, 0,    0, 0,   0,   0,  2'b00, 0,   0));
    rows.push_back(mk(0, 1, 1, 2,  0, 2'b00, 0, 0,    1, 0,   0,   0,  2'b00, 16,  0));
    rows.push_back(mk(0, 0, 0, 0,  1, 2'b01, 0, 0,    1, 0,   16,  0,  2'b00, 16,  1));
    rows.push_back(mk(0, 0, 0, 0,  1, 2'b11, 0, 1,    0, 1,   32,  16, 2'b00, 16,  2));

    foreach (rows[i]) begin
      row_t t;
      t = rows[i];
      drive(t.r, t.s, t.k, t.l, t.zv, t.zz, t.rs, t.stp);
      check($sformatf("vec%0d", i), observed(),
            {t.e_busy, t.e_done, t.e_b0, t.e_b1, t.e_sat, t.e_k, t.e_beats});
    end

    // Randomized run against the reference model, starting from reset.
    model_step(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("rand_reset", observed(), model_obs());
    for (int c = 0; c < 600; c++) begin
      logic r, s, zv, rs, stp;
      logic [3:0] k;
      logic [9:0] l;
      logic [1:0] zz;
      r   = ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 9) == 0);
      k   = 4'($urandom_range(0, 15));
      l   = 10'($urandom_range(0, 12));
      zv  = ($urandom_range(0, 3) != 0);
      zz  = 2'($urandom);
      rs  = ($urandom_range(0, 4) == 0);
      stp = ($urandom_range(0, 29) == 0);
      model_step(r, s, k, l, zv, zz, rs, stp);
      drive(r, s, k, l, zv, zz, rs, stp);
      check($sformatf("rand%0d", c), observed(), model_obs());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vsbc_mc.md
# vsbc_mc

Multi-channel variable-shift binary counter with built-in run control for early-terminating stochastic-computing evaluation. `N_CH` lanes share one weight register and accumulate the weight whenever their stochastic bit is 1. Weight and accumulators halve together on `rshift`. A small FSM owns the run: it starts on `start` and ends on beat limit, weight exhaustion or `stop`. It reports per-lane saturation and sits between the SC bitstream datapath and the result-capture logic.

## Interface
- `N_CH`, 4, number of lanes
- `W`, 4, width of `k_init`
- `B_W`, 12, accumulator and weight width (`B_W >= W`)
- `CNT_W`, 10, beat-counter and `len` width
- `clk`  in  1  clock
- `rst`  in  1  reset; **synchronous, active-high**
- `start`  in  1  begin a run; accepted in IDLE or DONE only
- `k_init`  in  W  initial weight; latched on accepted `start`
- `len`  in  CNT_W  maximum beats for the run; latched on accepted `start`
- `z_valid`  in  1  beat qualifier for `z` and `rshift`
- `z`  in  N_CH  one stochastic bit per lane
- `rshift`  in  1  halve weight and accumulators this beat
- `stop`  in  1  external early-termination request
- `busy`  out  1  high in RUN
- `done`  out  1  high in DONE
- `bz`  out  N_CH*B_W  accumulators; lane i at `[i*B_W +: B_W]`
- `sat`  out  N_CH  sticky per-lane saturation flags
- `k_cur`  out  B_W  current weight
- `beats`  out  CNT_W  beats accepted in the current or last run

## Operation
- FSM states: IDLE, RUN, DONE.
- **Accepted `start`**
  - Clears `bz`, `sat` and `beats`.
  - Loads `k_cur = {k_init, (B_W-W) zeros}`.
  - If `k_init == 0` or `len == 0`, goes to DONE. Otherwise goes to RUN.
- **`start` in RUN** is ignored.
- **RUN beat** (a `z_valid` cycle), per lane, in this order:
  1. Sum is `acc + k_cur` if `z[i]`, else `acc`. The sum is computed at B_W+1 bits.
  2. If the sum carries out, the result clamps to all-ones and `sat[i]` sets. `sat[i]` stays set until the next `start`.
  3. If `rshift`, the lane result is logically shifted right by 1 and `k_cur` is shifted right by 1.
  4. `beats` increments.
- **Non-`z_valid` cycles in RUN** leave all state unchanged.
- **RUN → DONE** when any of the following holds. Checks use post-beat values, and the triggering beat is fully applied.
  - `stop` is high. This check applies on any RUN cycle, beat or not.
  - The new `beats == len`.
  - The new `k_cur == 0`.
- **DONE** holds `bz`, `sat`, `k_cur` and `beats` stable until the next `start` or `rst`.
- **`rst`** returns the block to IDLE with every output zero, including mid-run.

## Timing
- All outputs are registered.
- A beat on cycle t is visible on `bz`, `sat`, `k_cur` and `beats` at t+1.
- `done` rises at t+1 after the terminating beat or the `stop` cycle.
- `start` at cycle t gives `busy=1` at t+1. For the zero-length case, it gives `done=1` at t+1.
- `start` in DONE restarts in one cycle: DONE → RUN with no IDLE visit.
- Reset values: `busy=0`, `done=0`, `bz=0`, `sat=0`, `k_cur=0`, `beats=0`.
- No bubbles: a beat is accepted on every `z_valid` cycle in RUN.

## Structure
- Package `vsbc_pkg`:
  - `vsbc_state_e` enum (IDLE/RUN/DONE)
  - helper function for weight load alignment
- Sub-module `vsbc_lane`:
  - one accumulator with saturating add, sticky flag and shift
  - instantiated `N_CH` times with a generate loop
  - inputs: `clk`, `rst`, `clr`, `en`, `z`, `rshift`, `k`
- Top level holds the FSM, shared weight register and beat counter.

## Test plan
Use N_CH=2, W=4, B_W=8. In each case `rshift=0` unless stated.
- **Basic:** `k_init=4'b0010` (k=32), `len=3`, three beats `z=2'b01` → `bz` lane0 32/64/96, lane1 0; `done` the cycle after beat 3; `beats=3`.
- **Shift:** k=32, `len=5`.
  - Beat 1: `z=11`, `rshift=1` → both lanes 16, `k_cur=16`.
  - Beat 2: `z=01` → lane0 32, lane1 16, still RUN.
- **Saturation:** `k_init=4'b1000` (k=128), `len=3`, three beats `z=01` → lane0 128, then 255 with `sat[0]=1`, then 255; `sat[1]=0`.
- **Weight exhaust:** `k_init=4'b0001` (k=16), `len=15`, `z=01` with `rshift` every beat → lane0 8, 8, 6, 4, 2 and `k_cur` 8, 4, 2, 1, 0; `done` after beat 5; `beats=5`.
- **Control edges:**
  - `len=0` → `done` the cycle after `start`, all zeros.
  - `start` during RUN → no effect.
  - `stop` with `z_valid=0` → DONE with values held.
  - `start` in DONE → clean restart.
- **Reset:** assert `rst` mid-run after 2 beats → next cycle IDLE with all outputs 0. A following `start` runs normally.
